// File: rtl/backprop_layer_sequencer.sv
// backprop_layer_sequencer
// Walks one shared backprop_neuron_core over every weight of a fully connected
// layer, in row-major order (neuron j outer, input i inner). It fetches the
// operands from the layer memories, runs the core through its enable/done
// handshake, writes the returned weight back and stores delta once per neuron.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     job request (sampled only while idle)
//   n_out_cfg, n_in_cfg       layer shape, legal 1..MAX_OUT / 1..MAX_IN
//   lr_cfg                    learning rate, captured at an accepted start
//   busy, done                job in progress / one-cycle completion pulse
//   cfg_err, timeout_err      one-cycle pulses: rejected start / stalled core
//   nrn_rd_en, nrn_addr       neuron read (act_cur_rdata, err_rdata next cycle)
//   prev_rd_en, prev_addr     previous-layer activation read (prev_rdata next cycle)
//   w_rd_en, w_wr_en, w_addr  weight port, address j*n_in+i
//   w_rdata, w_wdata          weight read data / write data
//   dlt_wr_en, dlt_addr, dlt_wdata  per-neuron delta store
//   core_*                    registered operands to the core, results and done back
module backprop_layer_sequencer #(
  parameter int WIDTH   = 16,
  parameter int MAX_OUT = 16,
  parameter int MAX_IN  = 16,
  parameter int TIMEOUT = 64,
  parameter int OAW     = $clog2(MAX_OUT),
  parameter int IAW     = $clog2(MAX_IN),
  parameter int WAW     = $clog2(MAX_OUT * MAX_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OAW:0]     n_out_cfg,
  input  logic [IAW:0]     n_in_cfg,
  input  logic [WIDTH-1:0] lr_cfg,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             timeout_err,
  output logic             nrn_rd_en,
  output logic [OAW-1:0]   nrn_addr,
  input  logic [WIDTH-1:0] act_cur_rdata,
  input  logic [WIDTH-1:0] err_rdata,
  output logic             prev_rd_en,
  output logic [IAW-1:0]   prev_addr,
  input  logic [WIDTH-1:0] prev_rdata,
  output logic             w_rd_en,
  output logic             w_wr_en,
  output logic [WAW-1:0]   w_addr,
  input  logic [WIDTH-1:0] w_rdata,
  output logic [WIDTH-1:0] w_wdata,
  output logic             dlt_wr_en,
  output logic [OAW-1:0]   dlt_addr,
  output logic [WIDTH-1:0] dlt_wdata,
  output logic             core_enable,
  output logic [WIDTH-1:0] core_act_cur,
  output logic [WIDTH-1:0] core_err_sum,
  output logic [WIDTH-1:0] core_act_prev,
  output logic [WIDTH-1:0] core_weight,
  output logic [WIDTH-1:0] core_lr,
  input  logic [WIDTH-1:0] core_delta,
  input  logic [WIDTH-1:0] core_new_weight,
  input  logic             core_done
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [OAW:0] MAX_OUT_C = (OAW+1)'(MAX_OUT);
  localparam logic [IAW:0] MAX_IN_C  = (IAW+1)'(MAX_IN);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_N, S_FETCH_W, S_LOAD, S_RUN, S_WRITE, S_RELEASE, S_FINISH
  } state_t;

  state_t         state;
  logic [OAW-1:0] j;
  logic [IAW-1:0] i;
  logic [WAW-1:0] w_ptr;
  logic [OAW:0]   n_out_q;
  logic [IAW:0]   n_in_q;
  logic           first_w;
  logic [WDW-1:0] wd;
  logic           cfg_ok;
  logic           last_i;
  logic           last_j;

  always_comb begin
    cfg_ok = (n_out_cfg != '0) && (n_out_cfg <= MAX_OUT_C) &&
             (n_in_cfg  != '0) && (n_in_cfg  <= MAX_IN_C);
    last_i = ((IAW+1)'(i) == n_in_q  - (IAW+1)'(1));
    last_j = ((OAW+1)'(j) == n_out_q - (OAW+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      j             <= '0;
      i             <= '0;
      w_ptr         <= '0;
      n_out_q       <= '0;
      n_in_q        <= '0;
      first_w       <= 1'b0;
      wd            <= '0;
      cfg_err       <= 1'b0;
      timeout_err   <= 1'b0;
      core_act_cur  <= '0;
      core_err_sum  <= '0;
      core_act_prev <= '0;
      core_weight   <= '0;
      core_lr       <= '0;
    end else begin
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              n_out_q <= n_out_cfg;
              n_in_q  <= n_in_cfg;
              core_lr <= lr_cfg;
              j       <= '0;
              i       <= '0;
              w_ptr   <= '0;
              state   <= S_FETCH_N;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_FETCH_N: begin
          first_w <= 1'b1;
          state   <= S_FETCH_W;
        end
        S_FETCH_W: begin
          // Neuron data read in FETCH_N is only valid on the first weight of the row.
          if (first_w) begin
            core_act_cur <= act_cur_rdata;
            core_err_sum <= err_rdata;
          end
          first_w <= 1'b0;
          state   <= S_LOAD;
        end
        S_LOAD: begin
          core_act_prev <= prev_rdata;
          core_weight   <= w_rdata;
          wd            <= '0;
          state         <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            state <= S_WRITE;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        S_WRITE: state <= S_RELEASE;
        S_RELEASE: begin
          // Wait for the core to drop done so the next enable starts a fresh op.
          if (!core_done) begin
            w_ptr <= w_ptr + WAW'(1);
            if (!last_i) begin
              i     <= i + IAW'(1);
              state <= S_FETCH_W;
            end else begin
              i <= '0;
              if (!last_j) begin
                j     <= j + OAW'(1);
                state <= S_FETCH_N;
              end else begin
                state <= S_FINISH;
              end
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_FINISH);
    nrn_rd_en   = (state == S_FETCH_N);
    prev_rd_en  = (state == S_FETCH_W);
    w_rd_en     = (state == S_FETCH_W);
    w_wr_en     = (state == S_WRITE);
    dlt_wr_en   = (state == S_WRITE) && (i == '0);
    core_enable = (state == S_RUN);
    nrn_addr    = nrn_rd_en ? j : '0;
    prev_addr   = prev_rd_en ? i : '0;
    w_addr      = (w_rd_en || w_wr_en) ? w_ptr : '0;
    w_wdata     = w_wr_en ? core_new_weight : '0;
    dlt_addr    = dlt_wr_en ? j : '0;
    dlt_wdata   = dlt_wr_en ? core_delta : '0;
  end

endmodule
